// File: rtl/seq_divider_pkg.sv
// Shared types for the RV32M sequential divider: funct3 op encoding and FSM states.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        DIV  = 3'b100,
        DIVU = 3'b101,
        REM  = 3'b110,
        REMU = 3'b111
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_lzc.sv
// Leading-zero counter used by the divider's early-out path.
// Only compiled when SEQ_DIV_EARLY_OUT_EN is defined; an all-zero input returns XLEN.
`ifdef SEQ_DIV_EARLY_OUT_EN
module div_lzc #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic [XLEN-1:0]  val_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan upward so the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = CNT_W'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (val_i[i]) cnt_o = CNT_W'(XLEN - 1 - i);
        end
    end

endmodule
`endif

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EXE; stalls the pipe while iterating.
// Define SEQ_DIV_EARLY_OUT_EN to skip the dividend's leading zeros (iterations = significant bits).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            divide_instruction,
    input  logic [2:0]      fun3_exe,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    input  logic            exe_advance,
    output logic            divide_stall,
    output logic [XLEN-1:0] div_result,
    output logic            div_result_valid
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             rsel_q, rsel_d;

    // ---------------- operand decode ----------------
    div_op_t          op;
    logic             signed_op, rem_sel;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             b_zero, ovf, a_zero, start;
    logic [XLEN-1:0]  dvd_init;
    logic [CNT_W-1:0] cnt_init;

    assign op = div_op_t'(fun3_exe);

    always_comb begin
        signed_op = 1'b0;
        rem_sel   = 1'b0;
        case (op)
            DIV:     signed_op = 1'b1;
            REM:     begin signed_op = 1'b1; rem_sel = 1'b1; end
            REMU:    rem_sel = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = signed_op & op_a[XLEN-1];
    assign b_neg  = signed_op & op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    assign b_zero = (op_b == '0);
    assign ovf    = signed_op && (op_a == MIN_NEG) && (op_b == '1);
    assign start  = (state_q == IDLE) && divide_instruction && !kill;

`ifdef SEQ_DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    div_lzc #(.XLEN(XLEN), .CNT_W(CNT_W)) u_lzc (
        .val_i (a_mag),
        .cnt_o (lz)
    );

    // Leading zeros would only produce leading zero quotient bits, so skip them.
    assign dvd_init = a_mag << lz;
    assign cnt_init = CNT_W'(XLEN) - lz;
    assign a_zero   = (a_mag == '0);
`else
    assign dvd_init = a_mag;
    assign cnt_init = CNT_W'(XLEN);
    assign a_zero   = 1'b0;
`endif

    // ---------------- one restoring step ----------------
    logic [XLEN:0]   sh, trial;
    logic            take, last_iter;
    logic [XLEN-1:0] rem_it, quo_it, q_fix, r_fix, res_it;

    // rem < divisor keeps sh - divisor inside XLEN+1 bits, so trial[XLEN] is its sign.
    assign sh        = {rem_q, quo_q[XLEN-1]};
    assign trial     = sh - {1'b0, dvs_q};
    assign take      = ~trial[XLEN];
    assign rem_it    = take ? trial[XLEN-1:0] : sh[XLEN-1:0];
    assign quo_it    = {quo_q[XLEN-2:0], take};
    assign q_fix     = qneg_q ? -quo_it : quo_it;
    assign r_fix     = rneg_q ? -rem_it : rem_it;
    assign res_it    = rsel_q ? r_fix : q_fix;
    assign last_iter = (cnt_q == CNT_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (b_zero || ovf || a_zero) ? DONE : BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (exe_advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        divide_stall = 1'b0;
        case (state_q)
            IDLE:    divide_stall = divide_instruction;
            BUSY:    divide_stall = 1'b1;
            default: ;
        endcase
        if (kill) divide_stall = 1'b0;
        div_result_valid = (state_q == DONE);
        div_result       = res_q;
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        res_d  = res_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        rsel_d = rsel_q;
        if (start) begin
            cnt_d  = cnt_init;
            rem_d  = '0;
            quo_d  = dvd_init;
            dvs_d  = b_mag;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            rsel_d = rem_sel;
            if (b_zero)      res_d = rem_sel ? op_a : '1;
            else if (ovf)    res_d = rem_sel ? '0 : MIN_NEG;
            else if (a_zero) res_d = '0;
        end else if (state_q == BUSY && !kill) begin
            rem_d = rem_it;
            quo_d = quo_it;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_iter) res_d = res_it;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            res_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            rsel_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            res_q  <= res_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            rsel_q <= rsel_d;
        end
    end

endmodule
